ps02_reschk: RTL and testbench
==============================

Name: ps02_reschk

Overview:
- Self-checking result monitor at the output end of the ps02 datapath.
- Captures each operand/opcode set the signal generator issues to the ALU and computes a reference result.
- Compares the ALU's R/flag against the reference after the ALU latency.
- Keeps pass/error statistics and a run status, so the bench and hardware report pass/fail without waveform inspection.

Parameters:
- data_width, 32, operand and result width in bits.
- LAT, 1, ALU latency in clock cycles from operand issue to R/flag valid; legal range 1..8.
- N_CHECKS, 64, number of compared results that completes a run.
- STOP_ON_ERR, 0, 1 = stop run on first mismatch; 0 = run to N_CHECKS.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; starts a run from IDLE, DONE or FAIL.
- valid_in  in  1  A/B/op on this cycle are a new ALU operation.
- A  in  data_width  operand A as issued to ALU.
- B  in  data_width  operand B as issued to ALU.
- op  in  3  opcode as issued to ALU.
- R  in  data_width  ALU result.
- flag  in  1  ALU flag.
- busy  out  1  state == RUN.
- done  out  1  run finished (DONE or FAIL).
- error  out  1  sticky: at least one mismatch this run.
- pass_cnt  out  16  matching results this run.
- err_cnt  out  16  mismatching results this run.
- first_err_idx  out  16  0-based check index of first mismatch; 0xFFFF if none.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, error=0, pass_cnt=0, err_cnt=0, first_err_idx=0xFFFF, all delay-line valid bits cleared. Applies immediately, including mid-run; no partial result survives.
- Reference model (combinational, on captured A/B/op), all results modulo 2^data_width:
  - Opcodes: 0 ADD A+B, 1 SUB A-B, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 A<<1, 7 A>>1 (logical).
  - Expected flag: ADD = carry out; SUB = borrow (A<B unsigned); opcodes 2..7 = result==0.
- Delay line: LAT-stage shift register of {v, A, B, op}.
  - Stage-0 v = valid_in & (state==RUN); start clears all v bits.
  - Entry issued at cycle t is compared against R/flag sampled at cycle t+LAT.
- Compare at cycle t+LAT when the delayed v=1 and state==RUN. Registered effects visible at t+LAT+1:
  - match: pass_cnt+1.
  - mismatch (R or flag differs): err_cnt+1, error=1; first_err_idx=check index if still 0xFFFF.
  - check index = pass_cnt+err_cnt before the update.
- Counters saturate at 0xFFFF.
- FSM:
  - IDLE: start -> RUN; counters cleared, error=0, first_err_idx=0xFFFF, done=0.
  - RUN: completing check number N_CHECKS -> DONE. A mismatch with STOP_ON_ERR=1 -> FAIL, which takes priority if it is also the last check. start is ignored in RUN.
  - DONE / FAIL: done=1; outputs frozen; valid_in and compares ignored. start -> RUN with the same clears as from IDLE.
- valid_in outside RUN is ignored. Results in flight when the run ends are discarded.
- Back-to-back valid_in every cycle is supported; throughput 1 check/cycle.

Test Plan:
- Reset/idle: rst=1 for 10 cycles, then valid_in toggling with no start -> busy=0, done=0, counters 0, first_err_idx=0xFFFF.
- Clean run, LAT=1, N_CHECKS=4: start, then 4 consecutive valid ops with ALU correct: ADD 0xFFFFFFFF+1 -> R=0, flag=1; SUB 3-5 -> R=0xFFFFFFFE, flag=1; AND 0xF0&0x0F -> R=0, flag=1; SHR1 0x8 -> R=0x4, flag=0. Expect pass_cnt=4, err_cnt=0, done=1 one cycle after the 4th compare, error=0.
- Injected error, STOP_ON_ERR=0, N_CHECKS=4: corrupt R on the 3rd op (XOR 0xA^0x5 returns 0xE instead of 0xF) -> pass_cnt=3, err_cnt=1, first_err_idx=2, error=1, done=1.
- STOP_ON_ERR=1, N_CHECKS=8: flag wrong on the 2nd op -> FAIL after that compare, err_cnt=1, pass_cnt=1, first_err_idx=1; later ops do not change counters.
- Latency, LAT=3: issue ops on 5 consecutive cycles with R/flag delayed 3 cycles -> 5 passes. The same stimulus with R delayed 2 cycles -> mismatches counted.
- Async reset mid-run: assert rst between clock edges after 2 of 4 checks -> all outputs at reset values immediately. Then a new start + 4 correct ops -> pass_cnt=4 with no stale entries counted.

Source files
------------

// File: rtl/ps02_reschk_if.sv
// ps02_reschk_if: issue/result/status bundle between the ps02 datapath and the result checker
interface ps02_reschk_if #(
    parameter int data_width = 32
);
    logic                  start;
    logic                  valid_in;
    logic [data_width-1:0] A;
    logic [data_width-1:0] B;
    logic [2:0]            op;
    logic [data_width-1:0] R;
    logic                  flag;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [15:0]           pass_cnt;
    logic [15:0]           err_cnt;
    logic [15:0]           first_err_idx;

    modport master (
        output start, valid_in, A, B, op, R, flag,
        input  busy, done, error, pass_cnt, err_cnt, first_err_idx
    );

    modport slave (
        input  start, valid_in, A, B, op, R, flag,
        output busy, done, error, pass_cnt, err_cnt, first_err_idx
    );
endinterface

// File: rtl/ps02_reschk.sv
// ps02_reschk: compares ALU R/flag against a reference model of the issued ops after LAT cycles
module ps02_reschk #(
    parameter int data_width  = 32,
    parameter int LAT         = 1,
    parameter int N_CHECKS    = 64,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input logic          clk,
    input logic          rst,
    ps02_reschk_if.slave mon
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

    state_t                state_q, state_d;
    logic [LAT-1:0]        v_q;
    logic [data_width-1:0] a_q [LAT];
    logic [data_width-1:0] b_q [LAT];
    logic [2:0]            op_q [LAT];
    logic [15:0]           pass_q, pass_d, err_q, err_d, fidx_q, fidx_d;
    logic                  error_q, error_d;
    logic                  run, go, cmp, match, last;
    logic [data_width-1:0] a, b, ref_r;
    logic [data_width:0]   sum;
    logic                  ref_f;
    logic [16:0]           total;

    assign run   = state_q == RUN;
    assign go    = mon.start && !run;
    assign a     = a_q[LAT-1];
    assign b     = b_q[LAT-1];
    assign sum   = {1'b0, a} + {1'b0, b};
    assign cmp   = run && v_q[LAT-1];
    assign match = ref_r == mon.R && ref_f == mon.flag;
    assign total = {1'b0, pass_q} + {1'b0, err_q} + 17'd1;
    assign last  = total == 17'(N_CHECKS);

    always_comb begin
        ref_r = '0;
        case (op_q[LAT-1])
            3'd0: ref_r = sum[data_width-1:0];
            3'd1: ref_r = a - b;
            3'd2: ref_r = a & b;
            3'd3: ref_r = a | b;
            3'd4: ref_r = a ^ b;
            3'd5: ref_r = ~a;
            3'd6: ref_r = a << 1;
            default: ref_r = a >> 1;
        endcase
        ref_f = op_q[LAT-1] == 3'd0 ? sum[data_width] :
                op_q[LAT-1] == 3'd1 ? a < b : ref_r == '0;
    end

    // only an accepted start flushes the delay line, so nothing from a previous run is compared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) v_q <= '0;
        else if (go) v_q <= '0;
        else begin
            v_q[0] <= mon.valid_in && run;
            for (int i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        a_q[0]  <= mon.A;
        b_q[0]  <= mon.B;
        op_q[0] <= mon.op;
        for (int i = 1; i < LAT; i++) begin
            a_q[i]  <= a_q[i-1];
            b_q[i]  <= b_q[i-1];
            op_q[i] <= op_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        err_d   = err_q;
        error_d = error_q;
        fidx_d  = fidx_q;
        if (go) begin
            state_d = RUN;
            pass_d  = '0;
            err_d   = '0;
            error_d = 1'b0;
            fidx_d  = '1;
        end else if (cmp) begin
            pass_d  = match && !(&pass_q) ? pass_q + 16'd1 : pass_q;
            err_d   = !match && !(&err_q) ? err_q + 16'd1 : err_q;
            error_d = error_q || !match;
            fidx_d  = !match && &fidx_q ? pass_q + err_q : fidx_q;
            state_d = !match && STOP_ON_ERR ? FAIL : last ? DONE : RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pass_q  <= '0;
            err_q   <= '0;
            error_q <= 1'b0;
            fidx_q  <= '1;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            error_q <= error_d;
            fidx_q  <= fidx_d;
        end
    end

    assign mon.busy          = run;
    assign mon.done          = state_q == DONE || state_q == FAIL;
    assign mon.error         = error_q;
    assign mon.pass_cnt      = pass_q;
    assign mon.err_cnt       = err_q;
    assign mon.first_err_idx = fidx_q;
endmodule

// File: tb/tb_ps02_reschk.sv
// tb_ps02_reschk: directed vectors against three checker configurations sharing one issue stream
module tb_ps02_reschk;
    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        f;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  st = '0;
    logic        vld = 1'b0;
    logic [31:0] a = '0, b = '0, r_now = '0;
    logic [2:0]  op = '0;
    logic        f_now = 1'b0;
    logic        dsel = 1'b0;
    logic [31:0] rp [3];
    logic        fp [3];
    int          n_cmp = 0;
    int          n_err = 0;
    vec_t        clean [4];
    vec_t        inj [4];
    vec_t        soe [4];
    vec_t        lat [5];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rp[0] <= r_now;
        fp[0] <= f_now;
        for (int i = 1; i < 3; i++) begin
            rp[i] <= rp[i-1];
            fp[i] <= fp[i-1];
        end
    end

    ps02_reschk_if #(.data_width(32)) ia ();
    ps02_reschk_if #(.data_width(32)) ib ();
    ps02_reschk_if #(.data_width(32)) ic ();

    assign ia.start = st[0];
    assign ib.start = st[1];
    assign ic.start = st[2];
    assign ia.valid_in = vld;
    assign ib.valid_in = vld;
    assign ic.valid_in = vld;
    assign ia.A = a;
    assign ib.A = a;
    assign ic.A = a;
    assign ia.B = b;
    assign ib.B = b;
    assign ic.B = b;
    assign ia.op = op;
    assign ib.op = op;
    assign ic.op = op;
    assign ia.R = rp[0];
    assign ib.R = rp[0];
    assign ic.R = dsel ? rp[1] : rp[2];
    assign ia.flag = fp[0];
    assign ib.flag = fp[0];
    assign ic.flag = dsel ? fp[1] : fp[2];

    ps02_reschk #(.data_width(32), .LAT(1), .N_CHECKS(4), .STOP_ON_ERR(1'b0)) u_a (.clk(clk), .rst(rst), .mon(ia));
    ps02_reschk #(.data_width(32), .LAT(1), .N_CHECKS(8), .STOP_ON_ERR(1'b1)) u_b (.clk(clk), .rst(rst), .mon(ib));
    ps02_reschk #(.data_width(32), .LAT(3), .N_CHECKS(5), .STOP_ON_ERR(1'b0)) u_c (.clk(clk), .rst(rst), .mon(ic));

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] r, input logic f);
        return '{op: o, a: x, b: y, r: r, f: f};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input vec_t v);
        @(negedge clk);
        st = '0;
        vld = 1'b1;
        a = v.a;
        b = v.b;
        op = v.op;
        r_now = v.r;
        f_now = v.f;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            st = '0;
            vld = 1'b0;
            r_now = '0;
            f_now = 1'b0;
        end
    endtask

    task automatic start(input int which);
        @(negedge clk);
        vld = 1'b0;
        st = '0;
        st[which] = 1'b1;
    endtask

    initial begin
        clean = '{mk(3'd0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1),
                  mk(3'd1, 32'h3, 32'h5, 32'hFFFF_FFFE, 1'b1),
                  mk(3'd2, 32'hF0, 32'h0F, 32'h0, 1'b1),
                  mk(3'd7, 32'h8, 32'h0, 32'h4, 1'b0)};
        inj   = '{mk(3'd0, 32'h1, 32'h2, 32'h3, 1'b0),
                  mk(3'd1, 32'h5, 32'h3, 32'h2, 1'b0),
                  mk(3'd4, 32'hA, 32'h5, 32'hE, 1'b0),
                  mk(3'd3, 32'h10, 32'h01, 32'h11, 1'b0)};
        soe   = '{mk(3'd0, 32'h2, 32'h2, 32'h4, 1'b0),
                  mk(3'd2, 32'hFF, 32'h0F, 32'h0F, 1'b1),
                  mk(3'd5, 32'h0, 32'h0, 32'hFFFF_FFFF, 1'b0),
                  mk(3'd4, 32'h5, 32'h5, 32'h1, 1'b1)};
        lat   = '{mk(3'd0, 32'd10, 32'd20, 32'd30, 1'b0),
                  mk(3'd1, 32'd100, 32'd1, 32'd99, 1'b0),
                  mk(3'd3, 32'h100, 32'h1, 32'h101, 1'b0),
                  mk(3'd6, 32'h40, 32'h0, 32'h80, 1'b0),
                  mk(3'd5, 32'hFFFF_FFF0, 32'h0, 32'hF, 1'b0)};

        repeat (10) @(negedge clk);
        check("rst_busy", 32'(ia.busy), 32'd0);
        check("rst_fidx", 32'(ia.first_err_idx), 32'hFFFF);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(clean[i]);
            idle(1);
        end
        check("idle_busy", 32'(ia.busy), 32'd0);
        check("idle_done", 32'(ia.done), 32'd0);
        check("idle_pass", 32'(ia.pass_cnt), 32'd0);
        check("idle_err", 32'(ia.err_cnt), 32'd0);
        check("idle_fidx", 32'(ia.first_err_idx), 32'hFFFF);
        check("idle_c_pass", 32'(ic.pass_cnt), 32'd0);

        start(0);
        @(negedge clk);
        check("clean_busy", 32'(ia.busy), 32'd1);
        for (int i = 0; i < 4; i++) issue(clean[i]);
        idle(1);
        check("clean_pass3", 32'(ia.pass_cnt), 32'd3);
        check("clean_notdone", 32'(ia.done), 32'd0);
        idle(1);
        check("clean_pass", 32'(ia.pass_cnt), 32'd4);
        check("clean_err", 32'(ia.err_cnt), 32'd0);
        check("clean_done", 32'(ia.done), 32'd1);
        check("clean_error", 32'(ia.error), 32'd0);
        check("clean_busy_end", 32'(ia.busy), 32'd0);
        check("clean_fidx", 32'(ia.first_err_idx), 32'hFFFF);
        issue(clean[0]);
        idle(2);
        check("done_frozen", 32'(ia.pass_cnt), 32'd4);

        start(0);
        for (int i = 0; i < 4; i++) issue(inj[i]);
        idle(2);
        check("inj_pass", 32'(ia.pass_cnt), 32'd3);
        check("inj_err", 32'(ia.err_cnt), 32'd1);
        check("inj_fidx", 32'(ia.first_err_idx), 32'd2);
        check("inj_error", 32'(ia.error), 32'd1);
        check("inj_done", 32'(ia.done), 32'd1);

        start(1);
        for (int i = 0; i < 4; i++) issue(soe[i]);
        idle(2);
        check("soe_pass", 32'(ib.pass_cnt), 32'd1);
        check("soe_err", 32'(ib.err_cnt), 32'd1);
        check("soe_fidx", 32'(ib.first_err_idx), 32'd1);
        check("soe_done", 32'(ib.done), 32'd1);
        check("soe_busy", 32'(ib.busy), 32'd0);
        check("soe_error", 32'(ib.error), 32'd1);

        start(2);
        for (int i = 0; i < 5; i++) issue(lat[i]);
        idle(3);
        check("lat3_notdone", 32'(ic.done), 32'd0);
        idle(1);
        check("lat3_pass", 32'(ic.pass_cnt), 32'd5);
        check("lat3_err", 32'(ic.err_cnt), 32'd0);
        check("lat3_done", 32'(ic.done), 32'd1);

        dsel = 1'b1;
        start(2);
        for (int i = 0; i < 5; i++) issue(lat[i]);
        idle(4);
        check("lat2_pass", 32'(ic.pass_cnt), 32'd0);
        check("lat2_err", 32'(ic.err_cnt), 32'd5);
        check("lat2_fidx", 32'(ic.first_err_idx), 32'd0);
        check("lat2_error", 32'(ic.error), 32'd1);
        dsel = 1'b0;

        start(0);
        for (int i = 0; i < 3; i++) issue(clean[i]);
        idle(1);
        check("mid_pass", 32'(ia.pass_cnt), 32'd2);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", 32'(ia.busy), 32'd0);
        check("ar_pass", 32'(ia.pass_cnt), 32'd0);
        check("ar_fidx", 32'(ia.first_err_idx), 32'hFFFF);
        check("ar_done", 32'(ib.done), 32'd0);
        check("ar_error", 32'(ib.error), 32'd0);
        check("ar_err", 32'(ib.err_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        start(0);
        for (int i = 0; i < 4; i++) issue(clean[i]);
        idle(2);
        check("post_pass", 32'(ia.pass_cnt), 32'd4);
        check("post_err", 32'(ia.err_cnt), 32'd0);
        check("post_done", 32'(ia.done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
